apb_fifo_drain_master: RTL and testbench

- Single-clock APB master that acts as the read side of the team's FIFO.
- Pops words through the FIFO read port (re / data_out / empty_flag) and issues one APB write per word.
- Write addresses step through a wrapping window that starts at BASE_ADDR.
- Sits in the pclk domain between the FIFO read port and the APB bus.

---
 rtl/apb_fifo_drain_master.sv | 157 +++++++++++++++
 tb/tb_apb_fifo_drain_master.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_fifo_drain_master.sv
// APB write master that drains the FIFO read port, one APB write per popped word.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_fifo_drain_master #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter int                    ADDR_STEP      = 4,
  parameter int                    WINDOW_BYTES   = 256,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_re,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  err_flag,
  output logic [7:0]            err_count,
  output logic [15:0]           xfer_count,
  output logic                  timeout_flag
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETUP  = 3'd3,
    ST_ACCESS = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STEP_C   = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] WINDOW_C = ADDR_WIDTH'(WINDOW_BYTES);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] offset_r;
  logic [ADDR_WIDTH-1:0] offset_next_s;
  logic                  more_s;
  logic                  timeout_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fifo_re       = (state_r == ST_POP);
  assign busy          = (state_r != ST_IDLE);
  assign more_s        = enable && !fifo_empty;
  assign offset_next_s = ((offset_r + STEP_C) == WINDOW_C) ? {ADDR_WIDTH{1'b0}} : (offset_r + STEP_C);

`ifdef APB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_cnt_r;
  logic          timeout_flag_r;

  assign timeout_s    = (state_r == ST_ACCESS) && !pready && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_r;

  // Counts consecutive not-ready ACCESS cycles and keeps the sticky timeout flag.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt_r      <= {TW{1'b0}};
      timeout_flag_r <= 1'b0;
    end else begin
      if ((state_r == ST_ACCESS) && !pready && !timeout_s) begin
        tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        tmo_cnt_r <= {TW{1'b0}};
      end
      if (timeout_s) begin
        timeout_flag_r <= 1'b1;
      end else if (err_clr) begin
        timeout_flag_r <= 1'b0;
      end else begin
        timeout_flag_r <= timeout_flag_r;
      end
    end
  end
`else
  assign timeout_s    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Main sequencer: pop, load, APB setup/access, then bookkeeping on completion.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r    <= ST_IDLE;
      offset_r   <= {ADDR_WIDTH{1'b0}};
      paddr      <= {ADDR_WIDTH{1'b0}};
      pwdata     <= {DATA_WIDTH{1'b0}};
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      err_flag   <= 1'b0;
      err_count  <= 8'd0;
      xfer_count <= 16'd0;
    end else begin
      if (err_clr) begin
        err_flag  <= 1'b0;
        err_count <= 8'd0;
      end
      case (state_r)
        ST_IDLE: begin
          if (more_s) begin
            state_r <= ST_POP;
          end
        end
        ST_POP: begin
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          pwdata  <= fifo_data;
          paddr   <= BASE_ADDR + offset_r;
          psel    <= 1'b1;
          pwrite  <= 1'b1;
          state_r <= ST_SETUP;
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state_r <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready) begin
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            xfer_count <= xfer_count + 16'd1;
            offset_r   <= offset_next_s;
            // A same-cycle clear must not hide this error, so the set path wins.
            if (pslverr) begin
              err_flag  <= 1'b1;
              err_count <= err_clr ? 8'd1 : sat_inc8(err_count);
            end
            state_r <= more_s ? ST_POP : ST_IDLE;
          end else if (timeout_s) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            state_r <= more_s ? ST_POP : ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_fifo_drain_master.sv
// Self-checking bench for apb_fifo_drain_master: FIFO model, completion monitor, scoreboard.
`timescale 1ns/1ps
module tb_apb_fifo_drain_master;

  logic        pclk = 1'b0;
  logic        presetn, enable, fifo_empty, fifo_re;
  logic [31:0] fifo_data = 32'd0;
  logic [31:0] paddr, pwdata;
  logic        psel, penable, pwrite, pready, pslverr, err_clr;
  logic        busy, err_flag, timeout_flag;
  logic [7:0]  err_count;
  logic [15:0] xfer_count;

  apb_fifo_drain_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h0000_0000),
    .ADDR_STEP(4), .WINDOW_BYTES(16), .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk), .presetn(presetn), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_re(fifo_re), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pready(pready),
    .pslverr(pslverr), .err_clr(err_clr), .busy(busy), .err_flag(err_flag),
    .err_count(err_count), .xfer_count(xfer_count), .timeout_flag(timeout_flag)
  );

  always #5 pclk = ~pclk;

  // FIFO model: data_out valid the cycle after re
  logic [31:0] fmem [0:15];
  logic [4:0]  wr_ptr = 5'd0;
  logic [4:0]  rd_ptr = 5'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge pclk) begin
    if (fifo_re) begin
      fifo_data <= fmem[rd_ptr[3:0]];
      rd_ptr    <= rd_ptr + 5'd1;
    end
  end

  // Completion monitor, sampled on the falling edge
  int          cyc = 0;
  int          obs_n = 0;
  int          re_empty_viol = 0;
  logic [31:0] obs_addr [0:255];
  logic [31:0] obs_data [0:255];
  int          obs_cyc  [0:255];
  always @(posedge pclk) cyc <= cyc + 1;
  always @(negedge pclk) begin
    if (presetn && psel && penable && pready) begin
      obs_addr[obs_n] <= paddr;
      obs_data[obs_n] <= pwdata;
      obs_cyc[obs_n]  <= cyc;
      obs_n           <= obs_n + 1;
    end
    if (fifo_re && fifo_empty) re_empty_viol <= re_empty_viol + 1;
  end

  int          checks = 0;
  int          failures = 0;
  int          obs_rd = 0;
  int          model_off = 0;
  logic [63:0] exp_q [$];
  logic [63:0] e;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] d, input bit expect_it);
    fmem[wr_ptr[3:0]] = d;
    wr_ptr = wr_ptr + 5'd1;
    if (expect_it) begin
      exp_q.push_back({32'(model_off), d});
      model_off = (model_off + 4) % 16;
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    int b = 0;
    while (obs_n < n && b < 100) begin
      step(1);
      b++;
    end
    ok = (obs_n >= n);
  endtask

  task automatic wait_access(output bit ok);
    int b = 0;
    while (!(psel && penable) && b < 30) begin
      step(1);
      b++;
    end
    ok = psel && penable;
  endtask

  task automatic reset_dut();
    presetn = 1'b0; enable = 1'b0; pready = 1'b1; pslverr = 1'b0; err_clr = 1'b0;
    step(2);
    presetn = 1'b1;
    step(1);
    model_off = 0;
    exp_q.delete();
    obs_rd = obs_n;
  endtask

  task automatic test_reset();
    presetn = 1'b0; enable = 1'b0; pready = 1'b1; pslverr = 1'b0; err_clr = 1'b0;
    step(2);
    checks++;
    if ({psel, penable, pwrite, fifo_re, busy, err_flag, timeout_flag} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000", {psel, penable, pwrite, fifo_re, busy, err_flag, timeout_flag});
    end
    checks++;
    if (paddr !== 32'd0 || pwdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus paddr=%h pwdata=%h exp=0", paddr, pwdata);
    end
    checks++;
    if (err_count !== 8'd0 || xfer_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_counts err_count=%0d xfer_count=%0d exp=0", err_count, xfer_count);
    end
    presetn = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    bit ok;
    push_word(32'hA1, 1'b1);
    push_word(32'hB2, 1'b1);
    push_word(32'hC3, 1'b1);
    enable = 1'b1;
    wait_obs(obs_rd + 3, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d exp=3", obs_n - obs_rd); end
    for (int k = 0; k < 3 && obs_rd < obs_n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL basic_xfer%0d got=%h/%h exp=%h", k, obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      if (k > 0) begin
        checks++;
        if (obs_cyc[obs_rd] - obs_cyc[obs_rd-1] !== 4) begin
          failures++;
          $display("FAIL basic_rate got=%0d exp=4", obs_cyc[obs_rd] - obs_cyc[obs_rd-1]);
        end
      end
      obs_rd++;
    end
    step(2);
    checks++;
    if (xfer_count !== 16'd3 || fifo_empty !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_end xfer=%0d empty=%b busy=%b exp=3/1/0", xfer_count, fifo_empty, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    reset_dut();
    for (int i = 0; i < 5; i++) push_word(32'h1000 + 32'(i), 1'b1);
    enable = 1'b1;
    wait_obs(obs_rd + 5, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_timeout got=%0d exp=5", obs_n - obs_rd); end
    for (int k = 0; k < 5 && obs_rd < obs_n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL wrap_xfer%0d got=%h/%h exp=%h", k, obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

  task automatic test_wait_states();
    bit ok;
    logic [31:0] a, d;
    pready = 1'b0;
    push_word(32'h5A5A_0001, 1'b1);
    wait_access(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_access got=0 exp=1"); end
    a = paddr;
    d = pwdata;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({paddr, pwdata, psel, penable} !== {a, d, 2'b11} || obs_n !== obs_rd) begin
        failures++;
        $display("FAIL wait_hold%0d got=%h/%h/%b%b exp=%h/%h/11", i, paddr, pwdata, psel, penable, a, d);
      end
      step(1);
    end
    pready = 1'b1;
    step(2);
    checks++;
    if (obs_n - obs_rd !== 1 || timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL wait_once got=%0d tmo=%b exp=1/0", obs_n - obs_rd, timeout_flag);
    end
    if (obs_rd < obs_n) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL wait_xfer got=%h/%h exp=%h", obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      obs_rd = obs_n;
    end
  endtask

  task automatic test_error();
    int b = 0;
    bit ok;
    reset_dut();
    push_word(32'hE0, 1'b1);
    push_word(32'hE1, 1'b1);
    push_word(32'hE2, 1'b1);
    enable = 1'b1;
    while ((obs_n - obs_rd) < 3 && b < 60) begin
      pslverr = psel && penable && ((obs_n - obs_rd) == 1);
      step(1);
      b++;
    end
    pslverr = 1'b0;
    for (int k = 0; k < 3 && obs_rd < obs_n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL err_xfer%0d got=%h/%h exp=%h", k, obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      obs_rd++;
    end
    checks++;
    if (err_flag !== 1'b1 || err_count !== 8'd1 || xfer_count !== 16'd3) begin
      failures++;
      $display("FAIL err_set flag=%b cnt=%0d xfer=%0d exp=1/1/3", err_flag, err_count, xfer_count);
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (err_flag !== 1'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL err_clear flag=%b cnt=%0d exp=0/0", err_flag, err_count);
    end
    // set and clear in the same completion cycle
    pready = 1'b0;
    push_word(32'hE3, 1'b1);
    wait_access(ok);
    pslverr = 1'b1; err_clr = 1'b1; pready = 1'b1;
    step(1);
    pslverr = 1'b0; err_clr = 1'b0;
    checks++;
    if (!ok || err_flag !== 1'b1 || err_count !== 8'd1) begin
      failures++;
      $display("FAIL err_set_wins flag=%b cnt=%0d exp=1/1", err_flag, err_count);
    end
    if (obs_rd < obs_n) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL err_xfer3 got=%h/%h exp=%h", obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      obs_rd = obs_n;
    end
  endtask

  task automatic test_enable_drop();
    int b = 0;
    bit re_seen = 1'b0;
    bit ok;
    reset_dut();
    push_word(32'hD0, 1'b1);
    push_word(32'hD1, 1'b1);
    enable = 1'b1;
    while (!(psel && !penable) && b < 20) begin
      step(1);
      b++;
    end
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (fifo_re) re_seen = 1'b1;
    end
    checks++;
    if (obs_n - obs_rd !== 1 || re_seen || busy !== 1'b0 || (wr_ptr - rd_ptr) !== 5'd1) begin
      failures++;
      $display("FAIL drop_state xfers=%0d re=%b busy=%b left=%0d exp=1/0/0/1", obs_n - obs_rd, re_seen, busy, wr_ptr - rd_ptr);
    end
    enable = 1'b1;
    wait_obs(obs_rd + 2, ok);
    for (int k = 0; k < 2 && obs_rd < obs_n; k++) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL drop_xfer%0d got=%h/%h exp=%h", k, obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      obs_rd++;
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    bit ok;
    reset_dut();
    pready = 1'b0;
    push_word(32'hF0, 1'b0);
    push_word(32'hF1, 1'b1);
    enable = 1'b1;
    wait_access(ok);
    while (psel && penable && n < 20) begin
      n++;
      step(1);
    end
    checks++;
    if (n !== 4 || timeout_flag !== 1'b1 || xfer_count !== 16'd0) begin
      failures++;
      $display("FAIL tmo_abort cycles=%0d flag=%b xfer=%0d exp=4/1/0", n, timeout_flag, xfer_count);
    end
    pready = 1'b1;
    wait_obs(obs_rd + 1, ok);
    if (obs_rd < obs_n) begin
      e = exp_q.pop_front();
      checks++;
      if ({obs_addr[obs_rd], obs_data[obs_rd]} !== e) begin
        failures++;
        $display("FAIL tmo_next got=%h/%h exp=%h", obs_addr[obs_rd], obs_data[obs_rd], e);
      end
      obs_rd = obs_n;
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checks++;
    if (timeout_flag !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got=%b exp=0", timeout_flag);
    end
  endtask
`endif

  task automatic test_async_reset();
    bit ok;
    enable = 1'b1;
    pready = 1'b0;
    push_word(32'hAB, 1'b0);
    wait_access(ok);
    step(1);
    #2;
    presetn = 1'b0;
    #1;
    checks++;
    if (!ok || {psel, penable, pwrite, busy} !== 4'b0 || paddr !== 32'd0 || pwdata !== 32'd0 || xfer_count !== 16'd0) begin
      failures++;
      $display("FAIL async_reset sel=%b en=%b busy=%b paddr=%h pwdata=%h exp=0", psel, penable, busy, paddr, pwdata);
    end
    step(1);
    presetn = 1'b1;
    pready = 1'b1;
    step(2);
    obs_rd = obs_n;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_wait_states();
    test_error();
    test_enable_drop();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    checks++;
    if (exp_q.size() !== 0 || re_empty_viol !== 0) begin
      failures++;
      $display("FAIL final_state pending=%0d re_while_empty=%0d exp=0/0", exp_q.size(), re_empty_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
